pkt_noc_arbiter: RTL and testbench
==================================

# pkt_noc_arbiter

Packet-granularity round-robin arbiter that merges NUM_IN Avalon-ST packet streams, each from a txr_to_noc instance with its vc_id/noc_dst sideband, onto one NoC injection stream. A packet is never interleaved: once its SOP beat is granted, the input holds the output until its EOP beat is accepted. The output is a single registered stage with full one-beat-per-cycle throughput, including back-to-back packets from different inputs.

## Interface
- DATA_WIDTH, 64, data bits per beat; EW = $clog2(DATA_WIDTH/8)
- NUM_IN, 4, number of requesting streams (≥2); IW = $clog2(NUM_IN)
- NUM_NOC_VC, 2, NoC virtual channels; VW = $clog2(NUM_NOC_VC)
- NOC_RADIX, 16, NoC routers; DW = $clog2(NOC_RADIX)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid / in_sop / in_eop  in  NUM_IN each  per-input beat qualifiers
- in_ready  out  NUM_IN  per-input accept
- in_data  in  NUM_IN*DATA_WIDTH  input i at [i*DATA_WIDTH +: DATA_WIDTH]
- in_empty  in  NUM_IN*EW  empty bytes on EOP beat
- in_vc_id  in  NUM_IN*VW;  in_noc_dst  in  NUM_IN*DW  sideband, sampled on SOP beat
- out_valid, out_sop, out_eop  out  1;  out_data  out  DATA_WIDTH;  out_empty  out  EW
- out_ready  in  1  downstream accept
- o_vc_id  out  VW;  o_noc_dst  out  DW  sideband of packet currently on output
- o_grant  out  IW  index of the input owning the current/last packet
- o_busy  out  1  high in LOCKED
- o_pkt_count  out  32  packets forwarded, wraps 2^32-1 -> 0

## Operation
- Beat transfer on a port when valid && ready, both sampled at posedge clk.
- Output register may load when out_ready || !out_valid (“load_ok”).
- States: IDLE, LOCKED. Reset -> IDLE, rr_ptr = NUM_IN-1 (input 0 highest priority first).
- IDLE: candidates = inputs with in_valid && in_sop. Winner = first candidate searching rr_ptr+1, rr_ptr+2, … modulo NUM_IN. in_ready[winner] = load_ok, all others 0. On transfer: load beat, latch grant = winner, latch that input's vc_id/noc_dst into o_vc_id/o_noc_dst. If beat also has eop (single-beat packet): stay IDLE, rr_ptr = winner, o_pkt_count++. Else -> LOCKED.
- LOCKED: in_ready[grant] = load_ok, others 0. Every transferred beat loads output. EOP transfer -> IDLE, rr_ptr = grant, o_pkt_count++.
- A valid beat without sop on a non-granted input in IDLE is never selected (held, in_ready 0).
- in_sop seen on granted input in LOCKED is forwarded unchanged; no recovery.
- Output register: on transfer loads data/sop/eop/empty, out_valid=1; else if out_ready, out_valid=0 (payload held). out_data etc. stable while out_valid && !out_ready.
- o_vc_id/o_noc_dst change only on an SOP transfer; valid with every beat of that packet.

## Timing
- Latency: input transfer at edge n -> beat on out_* from edge n through acceptance.
- Arbitration is combinational within the IDLE cycle; no bubble between EOP of one packet and SOP of the next (any input).
- o_grant, o_busy, rr_ptr, o_pkt_count update on the edge of the triggering transfer.
- Reset (async, any time, incl. mid-packet): out_valid=0, out_sop=0, out_eop=0, out_data=0, out_empty=0, o_vc_id=0, o_noc_dst=0, o_grant=0, o_busy=0, o_pkt_count=0, state IDLE, rr_ptr=NUM_IN-1; in_ready=0 while reset high. Partial packets are dropped; upstream re-sends.

## Test plan
- Single input 2 streams 3-beat packet, out_ready=1 -> 3 beats out 1 cycle later, sop on beat 1, eop+empty on beat 3, o_vc_id/o_noc_dst = input's values, o_pkt_count=1.
- All 4 inputs hold 2-beat packets from reset -> output order 0,1,2,3,0,…, 8 consecutive valid cycles, no interleave, no bubbles.
- Input 2 locked mid-packet while input 0 raises sop -> in_ready[0]=0 until input 2 EOP; input 0 follows next cycle.
- out_ready toggled 1,0,0,1 during a packet -> out_* stable while stalled, in_ready[grant]=0 only when out_valid && !out_ready, no beat lost/duplicated.
- Single-beat packets (sop+eop) on inputs 1 and 3 every cycle -> alternate 1,3,1,3, o_pkt_count +1 per cycle, o_busy stays 0.
- Reset asserted on beat 2 of a 4-beat packet -> all outputs to reset values immediately; after release input 0 wins first fresh SOP.

Source files
------------

// File: rtl/pkt_noc_arbiter_if.sv
// Stream bundle for pkt_noc_arbiter: NUM_IN packed request streams in,
// one merged NoC injection stream out, plus arbiter status.
interface pkt_noc_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned NUM_NOC_VC = 2,
    parameter int unsigned NOC_RADIX  = 16
);
    localparam int unsigned EW = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IW = $clog2(NUM_IN);
    localparam int unsigned VW = $clog2(NUM_NOC_VC);
    localparam int unsigned DW = $clog2(NOC_RADIX);

    // request side, input i occupies slice i of every packed bus
    logic [NUM_IN-1:0]            in_valid;
    logic [NUM_IN-1:0]            in_sop;
    logic [NUM_IN-1:0]            in_eop;
    logic [NUM_IN-1:0]            in_ready;
    logic [NUM_IN*DATA_WIDTH-1:0] in_data;
    logic [NUM_IN*EW-1:0]         in_empty;
    logic [NUM_IN*VW-1:0]         in_vc_id;
    logic [NUM_IN*DW-1:0]         in_noc_dst;

    // merged injection side
    logic                         out_valid;
    logic                         out_sop;
    logic                         out_eop;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [EW-1:0]                out_empty;
    logic [VW-1:0]                o_vc_id;
    logic [DW-1:0]                o_noc_dst;

    // status
    logic [IW-1:0]                o_grant;
    logic                         o_busy;
    logic [31:0]                  o_pkt_count;

    // source side: drives request streams and consumes the merged stream
    modport master (
        output in_valid, in_sop, in_eop, in_data, in_empty, in_vc_id, in_noc_dst,
        input  in_ready,
        input  out_valid, out_sop, out_eop, out_data, out_empty, o_vc_id, o_noc_dst,
        output out_ready,
        input  o_grant, o_busy, o_pkt_count
    );

    // arbiter side
    modport slave (
        input  in_valid, in_sop, in_eop, in_data, in_empty, in_vc_id, in_noc_dst,
        output in_ready,
        output out_valid, out_sop, out_eop, out_data, out_empty, o_vc_id, o_noc_dst,
        input  out_ready,
        output o_grant, o_busy, o_pkt_count
    );
endinterface

// File: rtl/pkt_noc_arbiter.sv
// pkt_noc_arbiter: packet-granular round-robin merge of NUM_IN Avalon-ST
// streams onto one registered NoC injection stream. A granted packet owns
// the output from its SOP beat until its EOP beat is accepted.
module pkt_noc_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned NUM_NOC_VC = 2,
    parameter int unsigned NOC_RADIX  = 16
) (
    input  logic             clk,
    input  logic             reset,
    pkt_noc_arbiter_if.slave bus
);
    localparam int unsigned EW = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IW = $clog2(NUM_IN);
    localparam int unsigned VW = $clog2(NUM_NOC_VC);
    localparam int unsigned DW = $clog2(NOC_RADIX);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    logic [IW-1:0]         r_rr_ptr;
    logic [IW-1:0]         r_grant;
    logic                  r_busy;
    logic [31:0]           r_pkt_count;
    logic                  r_out_valid;
    logic                  r_out_sop;
    logic                  r_out_eop;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [EW-1:0]         r_out_empty;
    logic [VW-1:0]         r_vc_id;
    logic [DW-1:0]         r_noc_dst;

    logic                  w_load_ok;
    logic                  w_found;
    logic [IW-1:0]         w_winner;
    logic [IW-1:0]         w_idx;
    logic [IW-1:0]         w_sel;
    logic                  w_active;
    logic                  w_xfer;
    logic                  w_sop;
    logic                  w_eop;
    logic [DATA_WIDTH-1:0] w_data;
    logic [EW-1:0]         w_empty;
    logic [VW-1:0]         w_vc;
    logic [DW-1:0]         w_dst;

    // output stage can take a new beat when empty or being drained this cycle
    assign w_load_ok = !r_out_valid || bus.out_ready;

    // round-robin search for the first SOP request after the last winner
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            w_idx = IW'((32'(r_rr_ptr) + k) % NUM_IN);
            if (!w_found && bus.in_valid[w_idx] && bus.in_sop[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // locked owner takes precedence; in IDLE only an SOP winner is eligible
    assign w_sel    = (r_state == ST_LOCKED) ? r_grant : w_winner;
    assign w_active = (r_state == ST_LOCKED) || w_found;
    assign w_xfer   = w_active && w_load_ok && bus.in_valid[w_sel];

    // beat and sideband of the selected input
    assign w_sop   = bus.in_sop[w_sel];
    assign w_eop   = bus.in_eop[w_sel];
    assign w_data  = bus.in_data[32'(w_sel) * DATA_WIDTH +: DATA_WIDTH];
    assign w_empty = bus.in_empty[32'(w_sel) * EW +: EW];
    assign w_vc    = bus.in_vc_id[32'(w_sel) * VW +: VW];
    assign w_dst   = bus.in_noc_dst[32'(w_sel) * DW +: DW];

    // only the selected input sees ready, and nobody does during reset
    always_comb begin
        bus.in_ready = '0;
        if (w_active && w_load_ok && !reset) begin
            bus.in_ready[w_sel] = 1'b1;
        end
    end

    // arbitration state, output register and status counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= IW'(NUM_IN - 1);
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_pkt_count <= '0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_data  <= '0;
            r_out_empty <= '0;
            r_vc_id     <= '0;
            r_noc_dst   <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_sop   <= w_sop;
                r_out_eop   <= w_eop;
                r_out_data  <= w_data;
                r_out_empty <= w_empty;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_grant   <= w_winner;
                        r_vc_id   <= w_vc;
                        r_noc_dst <= w_dst;
                        if (w_eop) begin
                            r_rr_ptr    <= w_winner;
                            r_pkt_count <= r_pkt_count + 32'd1;
                        end else begin
                            r_state <= ST_LOCKED;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer && w_eop) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_rr_ptr    <= r_grant;
                        r_pkt_count <= r_pkt_count + 32'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_sop     = r_out_sop;
    assign bus.out_eop     = r_out_eop;
    assign bus.out_data    = r_out_data;
    assign bus.out_empty   = r_out_empty;
    assign bus.o_vc_id     = r_vc_id;
    assign bus.o_noc_dst   = r_noc_dst;
    assign bus.o_grant     = r_grant;
    assign bus.o_busy      = r_busy;
    assign bus.o_pkt_count = r_pkt_count;
endmodule

// File: tb/tb_pkt_noc_arbiter.sv
// Bench for pkt_noc_arbiter: directed cycle table, hand-written round-robin
// and reset sequences, then randomized traffic against a behavioural model.
module tb_pkt_noc_arbiter;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned NUM_IN     = 4;
    localparam int unsigned NUM_NOC_VC = 2;
    localparam int unsigned NOC_RADIX  = 16;
    localparam int unsigned EW  = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IW  = $clog2(NUM_IN);
    localparam int unsigned VW  = $clog2(NUM_NOC_VC);
    localparam int unsigned DW  = $clog2(NOC_RADIX);
    localparam int unsigned OBW = 3 + EW + DATA_WIDTH + VW + DW + IW + 1 + 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pkt_noc_arbiter_if #(
        .DATA_WIDTH(DATA_WIDTH), .NUM_IN(NUM_IN),
        .NUM_NOC_VC(NUM_NOC_VC), .NOC_RADIX(NOC_RADIX)
    ) bus ();

    pkt_noc_arbiter #(
        .DATA_WIDTH(DATA_WIDTH), .NUM_IN(NUM_IN),
        .NUM_NOC_VC(NUM_NOC_VC), .NOC_RADIX(NOC_RADIX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus state, packed onto the bus by apply()
    logic [NUM_IN-1:0]     s_v, s_s, s_e;
    logic                  s_ordy;
    logic [DATA_WIDTH-1:0] s_d   [NUM_IN];
    logic [EW-1:0]         s_emp [NUM_IN];
    logic [VW-1:0]         s_vc  [NUM_IN];
    logic [DW-1:0]         s_dst [NUM_IN];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < int'(NUM_IN); i++) begin
            bus.in_data[i*DATA_WIDTH +: DATA_WIDTH] = s_d[i];
            bus.in_empty[i*EW +: EW]                = s_emp[i];
            bus.in_vc_id[i*VW +: VW]                = s_vc[i];
            bus.in_noc_dst[i*DW +: DW]              = s_dst[i];
        end
        bus.in_valid  = s_v;
        bus.in_sop    = s_s;
        bus.in_eop    = s_e;
        bus.out_ready = s_ordy;
    endtask

    function automatic logic [OBW-1:0] get_obs();
        return {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_empty, bus.out_data,
                bus.o_vc_id, bus.o_noc_dst, bus.o_grant, bus.o_busy, bus.o_pkt_count};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mkdata(input int i, input int row);
        return {8'(i + 1), 24'(row), 32'hC0DE_0000 | 32'(i)};
    endfunction

    // hold reset for one edge with all inputs idle, check the reset state
    task automatic do_reset();
        reset = 1'b1;
        s_v = '0; s_s = '0; s_e = '0; s_ordy = 1'b1;
        apply();
        @(posedge clk);
        #1;
        chk("reset_obs", 128'(get_obs()), 128'(0));
        chk("reset_ready", 128'(bus.in_ready), 128'(0));
        reset = 1'b0;
    endtask

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic [NUM_IN-1:0] v, s, e;
        logic              ordy;
        logic [NUM_IN-1:0] rdy;
        logic              ov, osop, oeop;
        int                src, row, grant;
        logic              busy;
        int                cnt;
    } vec_t;

    function automatic vec_t mk(input logic [NUM_IN-1:0] v, s, e, input logic ordy,
                                input logic [NUM_IN-1:0] rdy, input logic ov, osop, oeop,
                                input int src, row, grant, input logic busy, input int cnt);
        vec_t t;
        t.v = v; t.s = s; t.e = e; t.ordy = ordy; t.rdy = rdy;
        t.ov = ov; t.osop = osop; t.oeop = oeop;
        t.src = src; t.row = row; t.grant = grant; t.busy = busy; t.cnt = cnt;
        return t;
    endfunction

    task automatic run_table();
        vec_t tbl [21];
        // 3-beat packet on input 1
        tbl[0]  = mk(4'b0010, 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 0, 1, 0, 1, 1, 0);
        tbl[1]  = mk(4'b0010, 4'b0000, 4'b0000, 1, 4'b0010, 1, 0, 0, 1, 1, 1, 1, 0);
        tbl[2]  = mk(4'b0010, 4'b0000, 4'b0010, 1, 4'b0010, 1, 0, 1, 1, 2, 1, 0, 1);
        // input 2 locked while input 0 requests, input 0 follows without a bubble
        tbl[3]  = mk(4'b0100, 4'b0100, 4'b0000, 1, 4'b0100, 1, 1, 0, 2, 3, 2, 1, 1);
        tbl[4]  = mk(4'b0101, 4'b0001, 4'b0000, 1, 4'b0100, 1, 0, 0, 2, 4, 2, 1, 1);
        tbl[5]  = mk(4'b0101, 4'b0001, 4'b0100, 1, 4'b0100, 1, 0, 1, 2, 5, 2, 0, 2);
        tbl[6]  = mk(4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 1, 1, 0, 0, 6, 0, 1, 2);
        // out_ready 0,0,1 while input 0's packet is in flight
        tbl[7]  = mk(4'b0001, 4'b0000, 4'b0000, 0, 4'b0000, 1, 1, 0, 0, 6, 0, 1, 2);
        tbl[8]  = mk(4'b0001, 4'b0000, 4'b0000, 0, 4'b0000, 1, 1, 0, 0, 6, 0, 1, 2);
        tbl[9]  = mk(4'b0001, 4'b0000, 4'b0000, 1, 4'b0001, 1, 0, 0, 0, 9, 0, 1, 2);
        tbl[10] = mk(4'b0001, 4'b0000, 4'b0001, 1, 4'b0001, 1, 0, 1, 0, 10, 0, 0, 3);
        tbl[11] = mk(4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 3);
        // single-beat packets on 1 and 3 every cycle
        tbl[12] = mk(4'b1010, 4'b1010, 4'b1010, 1, 4'b0010, 1, 1, 1, 1, 12, 1, 0, 4);
        tbl[13] = mk(4'b1010, 4'b1010, 4'b1010, 1, 4'b1000, 1, 1, 1, 3, 13, 3, 0, 5);
        tbl[14] = mk(4'b1010, 4'b1010, 4'b1010, 1, 4'b0010, 1, 1, 1, 1, 14, 1, 0, 6);
        tbl[15] = mk(4'b1010, 4'b1010, 4'b1010, 1, 4'b1000, 1, 1, 1, 3, 15, 3, 0, 7);
        tbl[16] = mk(4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0, 3, 0, 7);
        // non-SOP beat in IDLE is never selected
        tbl[17] = mk(4'b0100, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0, 3, 0, 7);
        // empty output stage loads even with out_ready low, then holds
        tbl[18] = mk(4'b0001, 4'b0001, 4'b0001, 0, 4'b0001, 1, 1, 1, 0, 18, 0, 0, 8);
        tbl[19] = mk(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 1, 1, 1, 0, 18, 0, 0, 8);
        tbl[20] = mk(4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 8);

        do_reset();
        for (int r = 0; r < 21; r++) begin
            s_v = tbl[r].v; s_s = tbl[r].s; s_e = tbl[r].e; s_ordy = tbl[r].ordy;
            for (int i = 0; i < int'(NUM_IN); i++) begin
                s_d[i]   = mkdata(i, r);
                s_emp[i] = EW'(i + 1);
                s_vc[i]  = VW'(i % 2);
                s_dst[i] = DW'(4 + i);
            end
            apply();
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", r), 128'(bus.in_ready), 128'(tbl[r].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_ctl", r),
                128'({bus.out_valid, bus.o_grant, bus.o_busy, bus.o_pkt_count}),
                128'({tbl[r].ov, IW'(tbl[r].grant), tbl[r].busy, 32'(tbl[r].cnt)}));
            if (tbl[r].ov) begin
                chk($sformatf("tbl%0d_beat", r),
                    128'({bus.out_sop, bus.out_eop, bus.out_empty, bus.out_data, bus.o_vc_id, bus.o_noc_dst}),
                    128'({tbl[r].osop, tbl[r].oeop, EW'(tbl[r].src + 1), mkdata(tbl[r].src, tbl[r].row),
                          VW'(tbl[r].src % 2), DW'(4 + tbl[r].src)}));
            end
        end
    endtask

    // ---------------- all inputs with 2-beat packets from reset ----------------
    task automatic seq_rr();
        int b [NUM_IN];
        int w;
        logic [NUM_IN-1:0] er;
        do_reset();
        for (int i = 0; i < int'(NUM_IN); i++) b[i] = 0;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
                s_v[i] = 1'b1; s_s[i] = (b[i] == 0); s_e[i] = (b[i] == 1);
                s_d[i] = mkdata(i, 100 + c);
            end
            s_ordy = 1'b1;
            apply();
            w = (c / 2) % int'(NUM_IN);
            er = '0;
            er[w] = 1'b1;
            @(negedge clk);
            chk($sformatf("rr%0d_ready", c), 128'(bus.in_ready), 128'(er));
            @(posedge clk);
            for (int i = 0; i < int'(NUM_IN); i++) if (er[i]) b[i] = 1 - b[i];
            #1;
            chk($sformatf("rr%0d_out", c),
                128'({bus.out_valid, bus.out_sop, bus.out_eop, bus.o_grant, bus.o_busy, bus.o_pkt_count, bus.out_data}),
                128'({1'b1, (c % 2) == 0, (c % 2) == 1, IW'(w), (c % 2) == 0, 32'((c + 1) / 2), mkdata(w, 100 + c)}));
        end
    endtask

    // ---------------- async reset on beat 2 of a 4-beat packet ----------------
    task automatic seq_reset_mid();
        s_v = 4'b0100; s_s = 4'b0100; s_e = '0; s_ordy = 1'b1;
        apply();
        @(negedge clk);
        chk("mid_ready", 128'(bus.in_ready), 128'(4'b0100));
        @(posedge clk);
        #1;
        s_s = '0;
        apply();
        @(posedge clk);
        #1;
        chk("mid_locked", 128'({bus.o_busy, bus.o_grant, bus.o_pkt_count}), 128'({1'b1, IW'(2), 32'd8}));
        s_v = 4'b1101; s_s = 4'b1101;
        apply();
        #1;
        reset = 1'b1;
        #1;
        chk("mid_reset_obs", 128'(get_obs()), 128'(0));
        chk("mid_reset_ready", 128'(bus.in_ready), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 128'(bus.in_ready), 128'(4'b0001));
        @(posedge clk);
        #1;
        chk("post_reset_out", 128'({bus.out_valid, bus.out_sop, bus.o_grant, bus.o_busy, bus.o_pkt_count}),
            128'({1'b1, 1'b1, IW'(0), 1'b1, 32'd0}));
    endtask

    // ---------------- behavioural model for random traffic ----------------
    int                    m_owner;   // input holding the output, -1 when free
    int                    m_last;    // input that completed the most recent packet
    int                    m_xfer;    // input whose beat moved at the last edge, -1 none
    logic                  m_ov, m_sop, m_eop, m_busy;
    logic [EW-1:0]         m_emp;
    logic [DATA_WIDTH-1:0] m_data;
    logic [VW-1:0]         m_vc;
    logic [DW-1:0]         m_dst;
    logic [IW-1:0]         m_grant;
    logic [31:0]           m_cnt;

    task automatic model_reset();
        m_owner = -1; m_last = int'(NUM_IN) - 1; m_xfer = -1;
        m_ov = 0; m_sop = 0; m_eop = 0; m_busy = 0; m_emp = '0; m_data = '0;
        m_vc = '0; m_dst = '0; m_grant = '0; m_cnt = '0;
    endtask

    function automatic int model_pick();
        int j;
        if (m_owner >= 0) return m_owner;
        for (int k = 1; k <= int'(NUM_IN); k++) begin
            j = (m_last + k) % int'(NUM_IN);
            if (s_v[j] && s_s[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [NUM_IN-1:0] model_ready();
        logic [NUM_IN-1:0] r;
        int p;
        r = '0;
        p = model_pick();
        if (p >= 0 && (!m_ov || s_ordy)) r[p] = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        int p;
        p = model_pick();
        m_xfer = -1;
        if (p >= 0 && (!m_ov || s_ordy) && s_v[p]) begin
            m_xfer = p;
            m_ov = 1'b1; m_sop = s_s[p]; m_eop = s_e[p]; m_data = s_d[p]; m_emp = s_emp[p];
            if (m_owner < 0) begin
                m_grant = IW'(p); m_vc = s_vc[p]; m_dst = s_dst[p];
            end
            if (s_e[p]) begin
                m_owner = -1; m_last = p; m_cnt = m_cnt + 32'd1;
            end else begin
                m_owner = p;
            end
        end else if (s_ordy) begin
            m_ov = 1'b0;
        end
        m_busy = (m_owner >= 0);
    endtask

    function automatic logic [OBW-1:0] model_obs();
        return {m_ov, m_sop, m_eop, m_emp, m_data, m_vc, m_dst, m_grant, m_busy, m_cnt};
    endfunction

    task automatic run_random(input int ncyc);
        int rem [NUM_IN];
        model_reset();
        do_reset();
        for (int i = 0; i < int'(NUM_IN); i++) rem[i] = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            // new beats on idle inputs; a pending beat is held until accepted
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (!s_v[i] && $urandom_range(0, 2) != 0) begin
                    if (rem[i] == 0) begin
                        rem[i] = int'($urandom_range(1, 4));
                        s_s[i] = 1'b1;
                    end else begin
                        s_s[i] = 1'b0;
                    end
                    s_e[i]   = (rem[i] == 1);
                    s_v[i]   = 1'b1;
                    s_d[i]   = {$urandom, $urandom};
                    s_emp[i] = EW'($urandom);
                    s_vc[i]  = VW'($urandom);
                    s_dst[i] = DW'($urandom);
                end
            end
            s_ordy = ($urandom_range(0, 3) != 0);
            apply();
            @(negedge clk);
            chk("rand_ready", 128'(bus.in_ready), 128'(model_ready()));
            @(posedge clk);
            model_step();
            #1;
            chk("rand_out", 128'(get_obs()), 128'(model_obs()));
            if (cyc == ncyc / 2) begin
                reset = 1'b1;
                #1;
                model_reset();
                chk("rand_reset", 128'(get_obs()), 128'(model_obs()));
                for (int i = 0; i < int'(NUM_IN); i++) rem[i] = 0;
                s_v = '0;
                @(posedge clk);
                #1;
                reset = 1'b0;
            end else if (m_xfer >= 0) begin
                rem[m_xfer] = rem[m_xfer] - 1;
                s_v[m_xfer] = 1'b0;
            end
        end
    endtask

    initial begin
        s_v = '0; s_s = '0; s_e = '0; s_ordy = 1'b1;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            s_d[i] = '0; s_emp[i] = '0; s_vc[i] = '0; s_dst[i] = '0;
        end
        run_table();
        seq_rr();
        seq_reset_mid();
        run_random(3000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish by %0t, expected finish within 500000", $time);
        $fatal(1, "[TB] timeout");
    end
endmodule
